// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer
//   Ping-pong sector buffer feeding the SD single-block writer. 16-bit pixel
//   words are packed two bytes per word (high byte first) into two 512-byte
//   banks. Each full bank is presented to the writer along with its SD sector
//   address and streamed out one byte per rd_en. After SEC_LEN sectors have
//   been written, the buffer stops and raises frame_done.
//
// Ports
//   SD_clk      in   1   clock, all logic on posedge
//   rst         in   1   synchronous active-high reset
//   pix_valid   in   1   pixel word valid
//   pix_data    in   16  pixel word (RGB565)
//   pix_ready   out  1   buffer accepts a pixel word this cycle
//   wr_req      out  1   a full sector is ready for the writer
//   sec         out  32  SD sector address of the presented sector
//   rd_en       in   1   writer pulls the next byte
//   rd_data     out  8   byte for the previous rd_en
//   sec_done    in   1   writer finished the sector
//   frame_done  out  1   sticky, SEC_LEN sectors written
//
// Drain FSM
//   state  | meaning
//   R_IDLE | waiting for the drain bank to fill
//   R_XFER | wr_req high, streaming 512 bytes
//   R_WAIT | all bytes pulled, waiting for sec_done
//   R_DONE | picture complete, idle until reset
module sd_sector_buffer #(
    parameter logic [31:0] SEC_BASE = 32'd0,
    parameter logic [31:0] SEC_STEP = 32'd1,
    parameter logic [11:0] SEC_LEN  = 12'd3072
) (
    input  logic        SD_clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        wr_req,
    output logic [31:0] sec,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    input  logic        sec_done,
    output logic        frame_done
);

    typedef enum logic [1:0] {R_IDLE, R_XFER, R_WAIT, R_DONE} rstate_e;

    rstate_e     state_q, state_d;
    logic [15:0] mem_q [0:511];
    logic [1:0]  full_q, full_d;
    logic        fill_bank_q, fill_bank_d;
    logic        drain_bank_q, drain_bank_d;
    logic [7:0]  wptr_q, wptr_d;
    logic [8:0]  rptr_q, rptr_d;
    logic [11:0] filled_cnt_q, filled_cnt_d;
    logic [11:0] done_cnt_q, done_cnt_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] sec_q, sec_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        frame_done_q, frame_done_d;
    logic        accept;
    logic        fill_last;
    logic        sec_free;
    logic [15:0] rd_word;

    // A bank being freed this cycle still reads as full here, so a blocked
    // fill side resumes on the following cycle.
    assign pix_ready = !rst && !full_q[fill_bank_q] && (filled_cnt_q < SEC_LEN)
                       && (state_q != R_DONE);
    assign accept    = pix_valid && pix_ready;
    assign fill_last = accept && (wptr_q == 8'hFF);
    assign rd_word   = mem_q[{drain_bank_q, rptr_q[8:1]}];

    always_ff @(posedge SD_clk) begin
        if (accept) begin
            mem_q[{fill_bank_q, wptr_q}] <= pix_data;
        end
    end

    always_comb begin
        wptr_d       = wptr_q;
        fill_bank_d  = fill_bank_q;
        filled_cnt_d = filled_cnt_q;
        if (accept) begin
            wptr_d = wptr_q + 8'd1;
            if (fill_last) begin
                fill_bank_d  = !fill_bank_q;
                filled_cnt_d = filled_cnt_q + 12'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_bank_d = drain_bank_q;
        rptr_d       = rptr_q;
        done_cnt_d   = done_cnt_q;
        wr_req_d     = wr_req_q;
        sec_d        = sec_q;
        rd_data_d    = rd_data_q;
        frame_done_d = frame_done_q;
        sec_free     = 1'b0;
        full_d       = full_q;
        case (state_q)
            R_IDLE: begin
                if (full_q[drain_bank_q]) begin
                    state_d  = R_XFER;
                    wr_req_d = 1'b1;
                    rptr_d   = 9'd0;
                end
            end
            R_XFER: begin
                if (rd_en) begin
                    rd_data_d = rptr_q[0] ? rd_word[7:0] : rd_word[15:8];
                    rptr_d    = rptr_q + 9'd1;
                    if (rptr_q == 9'd511) begin
                        state_d  = R_WAIT;
                        wr_req_d = 1'b0;
                    end
                end
            end
            R_WAIT: begin
                if (sec_done) begin
                    sec_free     = 1'b1;
                    drain_bank_d = !drain_bank_q;
                    sec_d        = sec_q + SEC_STEP;
                    done_cnt_d   = done_cnt_q + 12'd1;
                    if (done_cnt_q + 12'd1 == SEC_LEN) begin
                        state_d      = R_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = R_IDLE;
                    end
                end
            end
            R_DONE: begin
                wr_req_d = 1'b0;
            end
            default: state_d = R_IDLE;
        endcase
        // Fill completion and free always target different banks, so both
        // updates can land in the same cycle.
        if (fill_last) full_d[fill_bank_q] = 1'b1;
        if (sec_free)  full_d[drain_bank_q] = 1'b0;
    end

    always_ff @(posedge SD_clk) begin
        if (rst) begin
            state_q      <= R_IDLE;
            full_q       <= 2'b00;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            wptr_q       <= 8'd0;
            rptr_q       <= 9'd0;
            filled_cnt_q <= 12'd0;
            done_cnt_q   <= 12'd0;
            wr_req_q     <= 1'b0;
            sec_q        <= SEC_BASE;
            rd_data_q    <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            filled_cnt_q <= filled_cnt_d;
            done_cnt_q   <= done_cnt_d;
            wr_req_q     <= wr_req_d;
            sec_q        <= sec_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign sec        = sec_q;
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
module tb_sd_sector_buffer;

    localparam logic [31:0] SEC_BASE = 32'd100;
    localparam logic [31:0] SEC_STEP = 32'd1;
    localparam logic [11:0] SEC_LEN  = 12'd4;

    logic        SD_clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        wr_req;
    logic [31:0] sec;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        sec_done;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: words accepted but not yet drained, bytes of the sector
    // currently being pulled, and count of sectors acknowledged.
    logic [15:0] mw[$];
    logic [7:0]  cur[$];
    int          mdone;

    always #5 SD_clk = ~SD_clk;

    sd_sector_buffer #(
        .SEC_BASE(SEC_BASE),
        .SEC_STEP(SEC_STEP),
        .SEC_LEN (SEC_LEN)
    ) dut (
        .SD_clk    (SD_clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .wr_req    (wr_req),
        .sec       (sec),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .sec_done  (sec_done),
        .frame_done(frame_done)
    );

    task automatic step();
        @(posedge SD_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_sec(input int n);
        return SEC_BASE + SEC_STEP * 32'(n);
    endfunction

    task automatic push_word(input logic [15:0] d);
        int n = 0;
        if ($urandom_range(0, 3) == 0) step();
        pix_valid = 1'b1;
        pix_data  = d;
        while (!pix_ready && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_wait pix_ready=%0b required 1", pix_ready);
        end else begin
            mw.push_back(d);
        end
        step();
        pix_valid = 1'b0;
    endtask

    task automatic push_random(input int cnt);
        for (int i = 0; i < cnt; i++) push_word(16'($urandom()));
    endtask

    task automatic start_sector();
        int n = 0;
        logic [15:0] w;
        while (wr_req !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (wr_req !== 1'b1) begin
            failures++;
            $display("FAIL wr_req_wait wr_req=%0b required 1", wr_req);
        end
        checks++;
        if (sec !== exp_sec(mdone)) begin
            failures++;
            $display("FAIL sec_addr sec=%0d required %0d", sec, exp_sec(mdone));
        end
        cur.delete();
        for (int i = 0; i < 256; i++) begin
            w = (mw.size() > 0) ? mw.pop_front() : 16'hXXXX;
            cur.push_back(w[15:8]);
            cur.push_back(w[7:0]);
        end
    endtask

    task automatic pull(input int cnt);
        logic [7:0] e;
        for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            e = (cur.size() > 0) ? cur.pop_front() : 8'hXX;
            checks++;
            if (rd_data !== e) begin
                failures++;
                $display("FAIL rd_byte rd_data=%02h required %02h", rd_data, e);
            end
        end
    endtask

    task automatic finish_sector();
        checks++;
        if (wr_req !== 1'b0) begin
            failures++;
            $display("FAIL wr_req_fall wr_req=%0b required 0", wr_req);
        end
        sec_done = 1'b1;
        step();
        sec_done = 1'b0;
        mdone++;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; rd_en = 1'b0; sec_done = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_pix_ready pix_ready=%0b required 0", pix_ready);
        end
        step();
        checks++;
        if (wr_req !== 1'b0 || sec !== SEC_BASE || rd_data !== 8'hFF || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state wr_req=%0b sec=%0d rd_data=%02h frame_done=%0b required 0 %0d FF 0",
                     wr_req, sec, rd_data, frame_done, SEC_BASE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_pix_ready pix_ready=%0b required 1", pix_ready);
        end
        mw.delete(); cur.delete(); mdone = 0;
    endtask

    task automatic test_single_sector();
        test_reset();
        for (int i = 0; i < 256; i++) push_word(16'(i));
        start_sector();
        pull(511);
        checks++;
        if (wr_req !== 1'b1) begin
            failures++;
            $display("FAIL wr_req_hold wr_req=%0b required 1", wr_req);
        end
        pull(1);
        finish_sector();
    endtask

    task automatic test_both_full();
        test_reset();
        push_random(512);
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL both_full_ready pix_ready=%0b required 0", pix_ready);
        end
        start_sector();
        pull(512);
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_free_ready pix_ready=%0b required 0", pix_ready);
        end
        sec_done = 1'b1;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL free_cycle_ready pix_ready=%0b required 0", pix_ready);
        end
        step();
        sec_done = 1'b0;
        mdone++;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_free_ready pix_ready=%0b required 1", pix_ready);
        end
        start_sector();
        pull(512);
        finish_sector();
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] last;
        test_reset();
        rd_en = 1'b1;
        step(); step(); step();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'hFF) begin
            failures++;
            $display("FAIL idle_rd_en rd_data=%02h required FF", rd_data);
        end
        push_random(256);
        start_sector();
        pull(10);
        sec_done = 1'b1;
        step();
        sec_done = 1'b0;
        checks++;
        if (wr_req !== 1'b1) begin
            failures++;
            $display("FAIL xfer_sec_done wr_req=%0b required 1", wr_req);
        end
        pull(502);
        finish_sector();
        last = rd_data;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== last) begin
            failures++;
            $display("FAIL idle_rd_hold rd_data=%02h required %02h", rd_data, last);
        end
    endtask

    task automatic test_frame();
        test_reset();
        push_random(512);
        start_sector(); pull(512); finish_sector();
        push_random(256);
        start_sector(); pull(512); finish_sector();
        push_random(256);
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL word1024_ready pix_ready=%0b required 0", pix_ready);
        end
        start_sector(); pull(512); finish_sector();
        checks++;
        if (pix_ready !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL count_limit pix_ready=%0b frame_done=%0b required 0 0", pix_ready, frame_done);
        end
        start_sector(); pull(512);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL early_frame_done frame_done=%0b required 0", frame_done);
        end
        finish_sector();
        step(); step();
        checks++;
        if (frame_done !== 1'b1 || pix_ready !== 1'b0 || wr_req !== 1'b0 || sec !== exp_sec(4)) begin
            failures++;
            $display("FAIL frame_end frame_done=%0b pix_ready=%0b wr_req=%0b sec=%0d required 1 0 0 %0d",
                     frame_done, pix_ready, wr_req, sec, exp_sec(4));
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        push_random(256);
        start_sector();
        pull(300);
        rst = 1'b1;
        step();
        checks++;
        if (wr_req !== 1'b0 || sec !== SEC_BASE || rd_data !== 8'hFF) begin
            failures++;
            $display("FAIL mid_reset wr_req=%0b sec=%0d rd_data=%02h required 0 %0d FF",
                     wr_req, sec, rd_data, SEC_BASE);
        end
        rst = 1'b0;
        mw.delete(); cur.delete(); mdone = 0;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready pix_ready=%0b required 1", pix_ready);
        end
        push_random(256);
        start_sector(); pull(512); finish_sector();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        test_reset();
        push_random(256);
        start_sector();
        pull(512);
        push_random(255);
        d = 16'($urandom());
        pix_valid = 1'b1;
        pix_data  = d;
        sec_done  = 1'b1;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready pix_ready=%0b required 1", pix_ready);
        end
        step();
        pix_valid = 1'b0;
        sec_done  = 1'b0;
        mw.push_back(d);
        mdone++;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_bank0_free pix_ready=%0b required 1", pix_ready);
        end
        step();
        checks++;
        if (wr_req !== 1'b1 || sec !== exp_sec(1)) begin
            failures++;
            $display("FAIL b2b_wr_req wr_req=%0b sec=%0d required 1 %0d", wr_req, sec, exp_sec(1));
        end
        start_sector(); pull(512); finish_sector();
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_data = 16'h0000; rd_en = 1'b0; sec_done = 1'b0;
        step();
        test_reset();
        test_single_sector();
        test_both_full();
        test_ignored_inputs();
        test_frame();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
